// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapath: default operand widths,
// controller state codes and the iteration counter sizing helper.
package arith_pkg;

    // Default widths match the 3-bit multiplier: 3-bit operands, 6-bit product.
    localparam int DW_DEF = 6;
    localparam int VW_DEF = 3;

    // Controller states. Plain constants keep older tools and modules happy.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bits needed for a counter that must be able to hold the value dw.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference only if it
// did not go negative.
module div_step
    import arith_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;

    // The partial remainder is always below the divisor, so the shifted value
    // fits comfortably and the top bit of the difference is a reliable sign.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        if (trial[VW+1]) begin
            q_bit   = 1'b0;
            rem_out = shifted[VW:0];
        end else begin
            q_bit   = 1'b1;
            rem_out = trial[VW:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, the inverse of the lab's 3-bit multiplier.
// A start pulse in IDLE or DONE loads the operands; one div_step is iterated
// DW times and the registered results appear with a one-cycle done pulse.
// A zero divisor skips the iterations and reports all-ones with dbz set.
module seq_divider
    import arith_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = cnt_width(DW);

    logic [1:0]    state;
    logic [DW-1:0] shift_reg;
    logic [VW:0]   part_rem;
    logic [VW-1:0] dvs_reg;
    logic [CW-1:0] count;
    logic          zero_div;
    logic          accept;
    logic [VW:0]   step_rem;
    logic          step_bit;

    // A new operation may begin whenever no iteration is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    div_step #(
        .VW(VW)
    ) u_step (
        .rem_in (part_rem),
        .bit_in (shift_reg[DW-1]),
        .divisor(dvs_reg),
        .rem_out(step_rem),
        .q_bit  (step_bit)
    );

    // Controller, datapath registers and registered outputs. RUN iterates while
    // the counter is non-zero and spends one final cycle publishing the result,
    // so a zero divisor (counter loaded with 0) publishes after a single cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            part_rem  <= '0;
            dvs_reg   <= '0;
            count     <= '0;
            zero_div  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state    <= RUN;
                busy     <= 1'b1;
                dbz      <= 1'b0;
                part_rem <= '0;
                dvs_reg  <= divisor;
                if (divisor == '0) begin
                    shift_reg <= '1;
                    count     <= '0;
                    zero_div  <= 1'b1;
                end else begin
                    shift_reg <= dividend;
                    count     <= CW'(DW);
                    zero_div  <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (count != '0) begin
                            shift_reg <= {shift_reg[DW-2:0], step_bit};
                            part_rem  <= step_rem;
                            count     <= count - CW'(1);
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            quotient  <= shift_reg;
                            remainder <= part_rem[VW-1:0];
                            dbz       <= zero_div;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
